// File: rtl/lc3_memaccess_seq.sv
// LC-3 MemAccess sequencer: one load/store per handshake, LDI/STI pointer fetch, held response.
// Optional per-phase request timeout when MEMACCESS_TIMEOUT_EN is defined.
module lc3_memaccess_seq #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              op_write,
  input  logic              M_Control,
  input  logic [ADDR_W-1:0] M_Addr,
  input  logic [DATA_W-1:0] M_Data,
  output logic [1:0]        mem_state,
  output logic              DMem_req,
  output logic              DMem_we,
  output logic [ADDR_W-1:0] DMem_addr,
  output logic [DATA_W-1:0] DMem_din,
  input  logic              DMem_ready,
  input  logic [DATA_W-1:0] DMem_dout,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // op_ready is high only in IDLE, DMem_ready completes one request phase, resp_valid holds until resp_ready.
  typedef enum logic [1:0] {IDLE, PTR, ACC, RESP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   r_resp_data;
  logic                w_in_req;
  logic                w_timeout;

  assign w_in_req = (r_state == PTR) || (r_state == ACC);

`ifdef MEMACCESS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // Final unanswered request cycle of a phase aborts it.
  assign w_timeout = w_in_req && !DMem_ready && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!w_in_req || (w_state_nxt != r_state)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if ((r_state == ACC) && DMem_ready) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign resp_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign resp_err  = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (op_valid) w_state_nxt = M_Control ? PTR : ACC;
      PTR: begin
        if (DMem_ready) w_state_nxt = ACC;
        else if (w_timeout) w_state_nxt = RESP;
      end
      ACC:  if (DMem_ready || w_timeout) w_state_nxt = RESP;
      RESP: if (resp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_addr holds the pointer address, then the fetched effective address.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_resp_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (op_valid) begin
            r_write <= op_write;
            r_addr  <= M_Addr;
            r_data  <= M_Data;
          end
        end
        PTR: begin
          if (DMem_ready) r_addr <= DMem_dout[ADDR_W-1:0];
          else if (w_timeout) r_resp_data <= '0;
        end
        ACC: begin
          if (DMem_ready) r_resp_data <= r_write ? '0 : DMem_dout;
          else if (w_timeout) r_resp_data <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_state = 2'b11;
    case (r_state)
      PTR:     mem_state = 2'b01;
      ACC:     mem_state = r_write ? 2'b10 : 2'b00;
      default: mem_state = 2'b11;
    endcase
  end

  assign op_ready   = (r_state == IDLE);
  assign DMem_req   = w_in_req;
  assign DMem_we    = (r_state == ACC) && r_write;
  assign DMem_addr  = r_addr;
  assign DMem_din   = r_data;
  assign resp_valid = (r_state == RESP);
  assign resp_data  = r_resp_data;

endmodule

// File: tb/tb_lc3_memaccess_seq.sv
// Directed testbench for lc3_memaccess_seq with a wait-state memory responder.
// Define MEMACCESS_TIMEOUT_EN to exercise the timeout abort instead of the unbounded wait.
module tb_lc3_memaccess_seq;
  logic        clock;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic        op_write;
  logic        M_Control;
  logic [15:0] M_Addr;
  logic [15:0] M_Data;
  logic [1:0]  mem_state;
  logic        DMem_req;
  logic        DMem_we;
  logic [15:0] DMem_addr;
  logic [15:0] DMem_din;
  logic        DMem_ready;
  logic [15:0] DMem_dout;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic        resp_err;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] mem [logic [15:0]];
  int wait_cfg    = 0;
  int wcnt        = 0;
  bit never_ready = 1'b0;

  lc3_memaccess_seq #(.DATA_W(16), .ADDR_W(16), .TIMEOUT_CYC(4)) dut (
    .clock(clock), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_write(op_write),
    .M_Control(M_Control), .M_Addr(M_Addr), .M_Data(M_Data),
    .mem_state(mem_state),
    .DMem_req(DMem_req), .DMem_we(DMem_we), .DMem_addr(DMem_addr), .DMem_din(DMem_din),
    .DMem_ready(DMem_ready), .DMem_dout(DMem_dout),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err)
  );

  // clock/reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit exp finish");
    $fatal(1);
  end

  // Memory responder: answers after wait_cfg unanswered request cycles.
  always @(negedge clock) begin
    if (DMem_req && !never_ready) begin
      if (wcnt == wait_cfg) begin
        DMem_ready = 1'b1;
        DMem_dout  = mem.exists(DMem_addr) ? mem[DMem_addr] : 16'h0000;
        if (DMem_we) mem[DMem_addr] = DMem_din;
        wcnt = 0;
      end else begin
        DMem_ready = 1'b0;
        wcnt++;
      end
    end else begin
      DMem_ready = 1'b0;
      if (!DMem_req) wcnt = 0;
    end
  end

  // driver tasks
  task automatic issue(input logic w, input logic ind, input logic [15:0] a, input logic [15:0] d);
    op_valid = 1'b1; op_write = w; M_Control = ind; M_Addr = a; M_Data = d;
    @(negedge clock);
    op_valid = 1'b0;
  endtask

  task automatic release_resp();
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; op_valid = 1'b0; op_write = 1'b0; M_Control = 1'b0;
    M_Addr = '0; M_Data = '0; resp_ready = 1'b0; DMem_ready = 1'b0; DMem_dout = '0;
    repeat (2) @(negedge clock);
    n_cmp++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL rst_op_ready: got %b exp 1", op_ready); end
    n_cmp++; if (mem_state !== 2'b11) begin n_fail++; $display("FAIL rst_mem_state: got %b exp 11", mem_state); end
    n_cmp++; if (DMem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b exp 0", DMem_req); end
    n_cmp++; if (DMem_addr !== 16'h0) begin n_fail++; $display("FAIL rst_addr: got %h exp 0000", DMem_addr); end
    n_cmp++; if ({resp_valid, resp_err, resp_data} !== 18'h0) begin n_fail++; $display("FAIL rst_resp: got %b%b%h exp all 0", resp_valid, resp_err, resp_data); end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_direct_load();
    wait_cfg = 0;
    mem[16'h3000] = 16'hBEEF;
    issue(1'b0, 1'b0, 16'h3000, 16'h0000);
    n_cmp++; if (DMem_req !== 1'b1 || DMem_we !== 1'b0) begin n_fail++; $display("FAIL ld_req: got req=%b we=%b exp req=1 we=0", DMem_req, DMem_we); end
    n_cmp++; if (mem_state !== 2'b00) begin n_fail++; $display("FAIL ld_mem_state: got %b exp 00", mem_state); end
    n_cmp++; if (DMem_addr !== 16'h3000) begin n_fail++; $display("FAIL ld_addr: got %h exp 3000", DMem_addr); end
    n_cmp++; if (op_ready !== 1'b0) begin n_fail++; $display("FAIL ld_op_ready_busy: got %b exp 0", op_ready); end
    @(negedge clock);
    n_cmp++; if (resp_valid !== 1'b1 || resp_data !== 16'hBEEF) begin n_fail++; $display("FAIL ld_resp: got v=%b d=%h exp v=1 d=beef", resp_valid, resp_data); end
    n_cmp++; if (DMem_req !== 1'b0) begin n_fail++; $display("FAIL ld_req_drop: got %b exp 0", DMem_req); end
    release_resp();
    n_cmp++; if (op_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL ld_back_idle: got rdy=%b v=%b exp rdy=1 v=0", op_ready, resp_valid); end
    n_cmp++; if (resp_data !== 16'hBEEF) begin n_fail++; $display("FAIL ld_data_kept: got %h exp beef", resp_data); end
  endtask

  task automatic test_store_wait();
    wait_cfg = 3;
    issue(1'b1, 1'b0, 16'h4000, 16'h1234);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (DMem_req !== 1'b1 || DMem_we !== 1'b1 || DMem_din !== 16'h1234 || DMem_addr !== 16'h4000 || mem_state !== 2'b10) begin
        n_fail++; $display("FAIL st_hold%0d: got req=%b we=%b din=%h addr=%h st=%b exp 1 1 1234 4000 10", i, DMem_req, DMem_we, DMem_din, DMem_addr, mem_state);
      end
      @(negedge clock);
    end
    n_cmp++; if (resp_valid !== 1'b1 || resp_data !== 16'h0 || resp_err !== 1'b0) begin n_fail++; $display("FAIL st_resp: got v=%b d=%h e=%b exp 1 0000 0", resp_valid, resp_data, resp_err); end
    n_cmp++; if (mem[16'h4000] !== 16'h1234) begin n_fail++; $display("FAIL st_mem: got %h exp 1234", mem[16'h4000]); end
    release_resp();
  endtask

  task automatic test_ldi();
    wait_cfg = 0;
    mem[16'h3010] = 16'h5000;
    mem[16'h5000] = 16'h00AA;
    issue(1'b0, 1'b1, 16'h3010, 16'h0000);
    n_cmp++; if (mem_state !== 2'b01 || DMem_addr !== 16'h3010 || DMem_req !== 1'b1 || DMem_we !== 1'b0) begin n_fail++; $display("FAIL ldi_ptr: got st=%b addr=%h req=%b we=%b exp 01 3010 1 0", mem_state, DMem_addr, DMem_req, DMem_we); end
    @(negedge clock);
    n_cmp++; if (mem_state !== 2'b00 || DMem_addr !== 16'h5000 || DMem_req !== 1'b1) begin n_fail++; $display("FAIL ldi_acc: got st=%b addr=%h req=%b exp 00 5000 1", mem_state, DMem_addr, DMem_req); end
    @(negedge clock);
    n_cmp++; if (resp_valid !== 1'b1 || resp_data !== 16'h00AA) begin n_fail++; $display("FAIL ldi_resp: got v=%b d=%h exp 1 00aa", resp_valid, resp_data); end
    release_resp();
  endtask

  task automatic test_sti();
    wait_cfg = 0;
    mem[16'h3020] = 16'h6000;
    issue(1'b1, 1'b1, 16'h3020, 16'h7777);
    n_cmp++; if (mem_state !== 2'b01 || DMem_addr !== 16'h3020 || DMem_we !== 1'b0) begin n_fail++; $display("FAIL sti_ptr: got st=%b addr=%h we=%b exp 01 3020 0", mem_state, DMem_addr, DMem_we); end
    @(negedge clock);
    n_cmp++; if (mem_state !== 2'b10 || DMem_addr !== 16'h6000 || DMem_we !== 1'b1 || DMem_din !== 16'h7777) begin n_fail++; $display("FAIL sti_acc: got st=%b addr=%h we=%b din=%h exp 10 6000 1 7777", mem_state, DMem_addr, DMem_we, DMem_din); end
    @(negedge clock);
    n_cmp++; if (resp_valid !== 1'b1 || resp_data !== 16'h0) begin n_fail++; $display("FAIL sti_resp: got v=%b d=%h exp 1 0000", resp_valid, resp_data); end
    n_cmp++; if (mem[16'h6000] !== 16'h7777) begin n_fail++; $display("FAIL sti_mem: got %h exp 7777", mem[16'h6000]); end
    release_resp();
  endtask

  task automatic test_resp_hold();
    wait_cfg = 0;
    mem[16'h3100] = 16'hCAFE;
    issue(1'b0, 1'b0, 16'h3100, 16'h0000);
    @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (resp_valid !== 1'b1 || resp_data !== 16'hCAFE || op_ready !== 1'b0 || DMem_req !== 1'b0) begin
        n_fail++; $display("FAIL hold%0d: got v=%b d=%h rdy=%b req=%b exp 1 cafe 0 0", i, resp_valid, resp_data, op_ready, DMem_req);
      end
      op_valid = (i % 2 == 0); M_Addr = 16'h3000; M_Control = 1'b0; op_write = 1'b0;
      @(negedge clock);
    end
    op_valid = 1'b0;
    release_resp();
    n_cmp++; if (op_ready !== 1'b1 || DMem_req !== 1'b0) begin n_fail++; $display("FAIL hold_ignored: got rdy=%b req=%b exp 1 0", op_ready, DMem_req); end
    @(negedge clock);
    n_cmp++; if (DMem_req !== 1'b0 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL hold_no_op: got req=%b v=%b exp 0 0", DMem_req, resp_valid); end
  endtask

  task automatic test_back_to_back();
    wait_cfg = 0;
    resp_ready = 1'b1;
    op_valid = 1'b1; op_write = 1'b0; M_Control = 1'b0; M_Addr = 16'h3000;
    @(negedge clock);
    n_cmp++; if (DMem_req !== 1'b1 || DMem_addr !== 16'h3000) begin n_fail++; $display("FAIL b2b_req1: got req=%b addr=%h exp 1 3000", DMem_req, DMem_addr); end
    M_Addr = 16'h3010;
    @(negedge clock);
    n_cmp++; if (resp_valid !== 1'b1 || resp_data !== 16'hBEEF) begin n_fail++; $display("FAIL b2b_resp1: got v=%b d=%h exp 1 beef", resp_valid, resp_data); end
    @(negedge clock);
    n_cmp++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b exp 1", op_ready); end
    @(negedge clock);
    op_valid = 1'b0;
    n_cmp++; if (DMem_req !== 1'b1 || DMem_addr !== 16'h3010) begin n_fail++; $display("FAIL b2b_req2: got req=%b addr=%h exp 1 3010", DMem_req, DMem_addr); end
    @(negedge clock);
    n_cmp++; if (resp_valid !== 1'b1 || resp_data !== 16'h5000) begin n_fail++; $display("FAIL b2b_resp2: got v=%b d=%h exp 1 5000", resp_valid, resp_data); end
    @(negedge clock);
    resp_ready = 1'b0;
    n_cmp++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: got %b exp 1", op_ready); end
  endtask

  task automatic test_reset_midphase();
    wait_cfg = 10;
    issue(1'b0, 1'b0, 16'h3000, 16'h0000);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    n_cmp++; if (DMem_req !== 1'b0 || mem_state !== 2'b11 || op_ready !== 1'b1) begin n_fail++; $display("FAIL midrst: got req=%b st=%b rdy=%b exp 0 11 1", DMem_req, mem_state, op_ready); end
    n_cmp++; if (DMem_addr !== 16'h0 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out: got addr=%h v=%b exp 0000 0", DMem_addr, resp_valid); end
    @(negedge clock);
    wait_cfg = 0;
    reset = 1'b1;
    issue(1'b0, 1'b0, 16'h3000, 16'h0000);
    n_cmp++; if (DMem_req !== 1'b1 || DMem_addr !== 16'h3000) begin n_fail++; $display("FAIL post_rst_accept: got req=%b addr=%h exp 1 3000", DMem_req, DMem_addr); end
    @(negedge clock);
    n_cmp++; if (resp_valid !== 1'b1 || resp_data !== 16'hBEEF) begin n_fail++; $display("FAIL post_rst_resp: got v=%b d=%h exp 1 beef", resp_valid, resp_data); end
    release_resp();
  endtask

`ifdef MEMACCESS_TIMEOUT_EN
  task automatic test_timeout();
    never_ready = 1'b1;
    issue(1'b0, 1'b1, 16'h3010, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (DMem_req !== 1'b1 || mem_state !== 2'b01) begin n_fail++; $display("FAIL to_req%0d: got req=%b st=%b exp 1 01", i, DMem_req, mem_state); end
      @(negedge clock);
    end
    n_cmp++; if (DMem_req !== 1'b0 || mem_state !== 2'b11) begin n_fail++; $display("FAIL to_drop: got req=%b st=%b exp 0 11", DMem_req, mem_state); end
    n_cmp++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_data !== 16'h0) begin n_fail++; $display("FAIL to_resp: got v=%b e=%b d=%h exp 1 1 0000", resp_valid, resp_err, resp_data); end
    never_ready = 1'b0;
    release_resp();
    n_cmp++; if (DMem_req !== 1'b0 || op_ready !== 1'b1) begin n_fail++; $display("FAIL to_no_acc: got req=%b rdy=%b exp 0 1", DMem_req, op_ready); end
  endtask
`else
  task automatic test_no_timeout();
    wait_cfg = 20;
    issue(1'b0, 1'b0, 16'h3000, 16'h0000);
    repeat (20) @(negedge clock);
    n_cmp++; if (DMem_req !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL long_wait: got req=%b v=%b exp 1 0", DMem_req, resp_valid); end
    @(negedge clock);
    n_cmp++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_data !== 16'hBEEF) begin n_fail++; $display("FAIL long_resp: got v=%b e=%b d=%h exp 1 0 beef", resp_valid, resp_err, resp_data); end
    release_resp();
  endtask
`endif

  initial begin
    test_reset();
    test_direct_load();
    test_store_wait();
    test_ldi();
    test_sti();
    test_resp_hold();
    test_back_to_back();
    test_reset_midphase();
`ifdef MEMACCESS_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_memaccess_seq.md
# lc3_memaccess_seq

Parametrised LC-3 MemAccess sequencer sitting between the Execute/Writeback control path and the data memory. It accepts one load/store operation per handshake, including indirect (LDI/STI) two-phase accesses. It drives a request/ready data-memory port that tolerates any number of wait states, then returns a held response with optional timeout error reporting.

## Interface
- DATA_W, 16, data word width
- ADDR_W, 16, memory address width; must be ≤ DATA_W (indirect pointer = low ADDR_W bits of fetched word)
- TIMEOUT_CYC, 15, max DMem_req cycles per phase before abort (used only with timeout feature)

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- op_valid  in  1  operation offered
- op_ready  out  1  sequencer can accept; reset 1
- op_write  in  1  1 = store, 0 = load
- M_Control  in  1  1 = indirect (pointer fetch first)
- M_Addr  in  ADDR_W  effective/pointer address
- M_Data  in  DATA_W  store data
- mem_state  out  2  phase: 2'b11 idle, 2'b01 pointer read, 2'b00 read, 2'b10 write; reset 2'b11
- DMem_req  out  1  memory request; reset 0
- DMem_we  out  1  write strobe, valid with DMem_req; reset 0
- DMem_addr  out  ADDR_W  request address; reset 0
- DMem_din  out  DATA_W  write data; reset 0
- DMem_ready  in  1  request completes this cycle; read data valid
- DMem_dout  in  DATA_W  read data
- resp_valid  out  1  response available; reset 0
- resp_ready  in  1  consumer takes response
- resp_data  out  DATA_W  load result (0 for stores/errors); reset 0
- resp_err  out  1  timeout abort; reset 0

## Operation
- FSM states: IDLE, PTR, ACC, RESP.
- IDLE
  - op_ready=1.
  - On op_valid: latch op_write, M_Control, M_Addr, M_Data.
  - Go to PTR if M_Control, else ACC.
- PTR
  - DMem_req=1, DMem_we=0, DMem_addr=latched addr, mem_state=01.
  - On DMem_ready: address reg ← DMem_dout[ADDR_W-1:0], go to ACC.
- ACC
  - DMem_req=1, DMem_we=op_write, DMem_addr=address reg, DMem_din=latched data.
  - mem_state=10 for store, 00 for load.
  - On DMem_ready: resp_data ← load ? DMem_dout : 0, resp_err←0, go to RESP.
- RESP
  - resp_valid=1, held with resp_data/resp_err stable until resp_ready.
  - Then go to IDLE; resp_data remains until overwritten.
- op_ready=0 outside IDLE; op_valid there is ignored (not latched).
- DMem_ready outside PTR/ACC is ignored.
- DMem_req drops in the cycle after DMem_ready; never two completions per phase.
- Non-IDLE states: DMem_addr/DMem_din/DMem_we reflect the current phase. Outside PTR/ACC: DMem_req=0, DMem_we=0.

## Timing
- All outputs registered from FSM state; no combinational input→output paths.
- Zero-wait memory (DMem_ready in first request cycle), accept at cycle 0:
  - Direct op: request cycle 1, resp_valid cycle 2.
  - Indirect op: pointer request cycle 1, final request cycle 2, resp_valid cycle 3.
- Each wait state adds one cycle to its phase.
- resp_valid with resp_ready at cycle N: op_ready=1 at N+1. Back-to-back throughput is one op per 3 cycles (direct) or 4 cycles (indirect).
- reset low at any time, including mid-phase: immediate return to IDLE, all outputs to reset values, in-flight op discarded. First accept is possible on the first rising edge after release.

## Configuration
- MEMACCESS_TIMEOUT_EN defined:
  - A per-phase counter of width $clog2(TIMEOUT_CYC+1) clears on phase entry.
  - It increments each request cycle without DMem_ready.
  - After TIMEOUT_CYC request cycles with no ready, DMem_req drops and the FSM enters RESP with resp_err=1, resp_data=0.
  - An indirect op that times out in PTR never issues ACC.
- Not defined: no counter; the FSM waits indefinitely in PTR/ACC and resp_err is tied 0.

## Test plan
- Direct load, M_Addr=16'h3000, memory returns 16'hBEEF with 0 waits:
  - DMem_req cycle 1, mem_state=00.
  - resp_valid cycle 2, resp_data=16'hBEEF.
- Direct store, M_Addr=16'h4000, M_Data=16'h1234, 3 wait states:
  - DMem_we=1, DMem_din=16'h1234 held for 4 cycles.
  - resp_data=0, resp_err=0.
- LDI, M_Addr=16'h3010:
  - Mem[3010]=16'h5000, Mem[5000]=16'h00AA.
  - mem_state goes 01 then 00; second DMem_addr=16'h5000.
  - resp_data=16'h00AA at cycle 3.
- STI, M_Addr=16'h3020, Mem[3020]=16'h6000, M_Data=16'h7777: write issued to 16'h6000 with mem_state=10.
- resp_ready held low 5 cycles:
  - resp_valid/resp_data stable throughout.
  - op_ready=0 throughout; op_valid pulses during that time are ignored.
- With MEMACCESS_TIMEOUT_EN and TIMEOUT_CYC=4, DMem_ready never asserted: DMem_req for exactly 4 cycles, then resp_err=1.
- Reset asserted during an ACC wait state: DMem_req=0, mem_state=11, and op_ready=1 immediately.
